// File: rtl/operand_fwd_stage.sv
// Operand forwarding select with load-use stall, flush and a valid/ready ID/EX operand register.
// Optional FWD_STALL_CNT_EN adds a saturating load-use stall counter on Stall_Cnt.
module operand_fwd_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SW    = $clog2(NSRC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [AW-1:0]               Rs_Addr,
  input  logic [WIDTH-1:0]            Rf_Data,
  input  logic [NSRC-2:0]             Fwd_WrEn,
  input  logic [NSRC-2:0]             Fwd_Pend,
  input  logic [(NSRC-1)*AW-1:0]      Fwd_Addr,
  input  logic [(NSRC-1)*WIDTH-1:0]   Fwd_Data,
  input  logic                        Flush,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [WIDTH-1:0]            Out_Data,
  output logic [SW-1:0]               Out_Sel,
  output logic [15:0]                 Stall_Cnt
);

  logic [NSRC-2:0]  match;
  logic             found;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] sel_data;
  logic             hazard;
  logic             capture;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_sel_q;

  // Address 0 never matches so x0 always reads the register file.
  always_comb begin
    for (int i = 0; i < int'(NSRC) - 1; i++) begin
      match[i] = Fwd_WrEn[i] && (Fwd_Addr[i*AW +: AW] == Rs_Addr) && (Rs_Addr != '0);
    end
  end

  // Lowest index is the youngest in-flight result and therefore wins.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = Rf_Data;
    hazard   = 1'b0;
    for (int i = 0; i < int'(NSRC) - 1; i++) begin
      if (!found && match[i]) begin
        found    = 1'b1;
        sel      = SW'(i + 1);
        sel_data = Fwd_Data[i*WIDTH +: WIDTH];
        hazard   = Fwd_Pend[i];
      end
    end
  end

  assign In_Ready = (!out_valid_q || Out_Ready) && !hazard;
  assign capture  = In_Valid && In_Ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (out_valid_q && Out_Ready) out_valid_d = 1'b0;
    if (capture)                  out_valid_d = 1'b1;
    if (Flush)                    out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      // A flushed capture still loads the data path; it is marked invalid.
      if (capture) begin
        out_data_q <= sel_data;
        out_sel_q  <= sel;
      end
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Data  = out_data_q;
  assign Out_Sel   = out_sel_q;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (In_Valid && hazard && !Flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`else
  assign Stall_Cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage: vector table for select/priority, hand sequences for
// load-use stall, back-pressure, flush, mid-transfer reset and stall-counter saturation.
module tb_operand_fwd_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [31:0] rf_data;
  logic [2:0]  fwd_wren;
  logic [2:0]  fwd_pend;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  operand_fwd_stage #(
    .WIDTH(32),
    .AW   (5),
    .NSRC (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .In_Valid (in_valid),
    .In_Ready (in_ready),
    .Rs_Addr  (rs_addr),
    .Rf_Data  (rf_data),
    .Fwd_WrEn (fwd_wren),
    .Fwd_Pend (fwd_pend),
    .Fwd_Addr (fwd_addr),
    .Fwd_Data (fwd_data),
    .Flush    (flush),
    .Out_Valid(out_valid),
    .Out_Ready(out_ready),
    .Out_Data (out_data),
    .Out_Sel  (out_sel),
    .Stall_Cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [31:0] rf;
    logic [2:0]  wren;
    logic [2:0]  pend;
    logic [14:0] faddr;
    logic [95:0] fdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[8];

  localparam logic [95:0] FDATA = {32'hCCCC_0000, 32'hBBBB_0000, 32'hAAAA_0000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef FWD_STALL_CNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'h0001 : 16'h0000;
`endif
  endfunction

  initial begin
    // {rs, rf, wren, pend, faddr{a2,a1,a0}, fdata, exp_data, exp_sel}
    vecs[0] = '{5'd5,  32'h1111_1111, 3'b000, 3'b000, {5'd5,  5'd5,  5'd5},  FDATA,
                32'h1111_1111, 2'd0};
    vecs[1] = '{5'd7,  32'h0000_0007, 3'b101, 3'b000, {5'd7,  5'd3,  5'd7},  FDATA,
                32'hAAAA_0000, 2'd1};
    vecs[2] = '{5'd0,  32'h1234_5678, 3'b111, 3'b000, {5'd0,  5'd0,  5'd0},  FDATA,
                32'h1234_5678, 2'd0};
    vecs[3] = '{5'd9,  32'h0000_0009, 3'b111, 3'b000, {5'd9,  5'd4,  5'd3},  FDATA,
                32'hCCCC_0000, 2'd3};
    vecs[4] = '{5'd12, 32'h0000_000C, 3'b010, 3'b000, {5'd12, 5'd12, 5'd12}, FDATA,
                32'hBBBB_0000, 2'd2};
    vecs[5] = '{5'd6,  32'h0000_0006, 3'b111, 3'b110, {5'd6,  5'd6,  5'd6},  FDATA,
                32'hAAAA_0000, 2'd1};
    vecs[6] = '{5'd31, 32'hDEAD_BEEF, 3'b111, 3'b000, {5'd30, 5'd29, 5'd28}, FDATA,
                32'hDEAD_BEEF, 2'd0};
    vecs[7] = '{5'd0,  32'h0BAD_F00D, 3'b111, 3'b111, {5'd0,  5'd0,  5'd0},  FDATA,
                32'h0BAD_F00D, 2'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rs_addr   = '0;
    rf_data   = '0;
    fwd_wren  = '0;
    fwd_pend  = '0;
    fwd_addr  = '0;
    fwd_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back captures, one vector per cycle with Out_Ready high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rs_addr  = vecs[i].rs;
      rf_data  = vecs[i].rf;
      fwd_wren = vecs[i].wren;
      fwd_pend = vecs[i].pend;
      fwd_addr = vecs[i].faddr;
      fwd_data = vecs[i].fdata;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
    end

    // Asynchronous reset mid-cycle while holding a valid output.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset out_data", out_data, 32'd0);
    chk("async reset out_sel", 32'(out_sel), 32'd0);
    chk("async reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Load-use: source 0 matches but is pending for two cycles.
    @(negedge clk);
    in_valid = 1'b1;
    rs_addr  = 5'd8;
    rf_data  = 32'h0000_0008;
    fwd_wren = 3'b001;
    fwd_pend = 3'b001;
    fwd_addr = {5'd0, 5'd0, 5'd8};
    fwd_data = {32'h0, 32'h0, 32'h5555_0001};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("load-use stall%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("load-use stall%0d out_valid", c), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("load-use stall_cnt", 32'(stall_cnt), 32'(exp_cnt(2)));
    fwd_pend = 3'b000;
    fwd_data = {32'h0, 32'h0, 32'h5555_0002};
    #1;
    chk("load-use release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("load-use capture out_valid", 32'(out_valid), 32'd1);
    chk("load-use capture out_data", out_data, 32'h5555_0002);
    chk("load-use capture out_sel", 32'(out_sel), 32'd1);
    chk("load-use stall_cnt hold", 32'(stall_cnt), 32'(exp_cnt(2)));

    // Back-pressure: output held three cycles, then back-to-back captures.
    @(negedge clk);
    out_ready = 1'b0;
    rs_addr   = 5'd3;
    rf_data   = 32'h3333_3333;
    fwd_wren  = 3'b000;
    #1;
    chk("backpressure in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("backpressure hold%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("backpressure hold%0d out_data", c), out_data, 32'h5555_0002);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("backpressure release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b first out_data", out_data, 32'h3333_3333);
    chk("b2b first out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rs_addr = 5'd4;
    rf_data = 32'h4444_4444;
    @(posedge clk);
    #1;
    chk("b2b second out_data", out_data, 32'h4444_4444);
    chk("b2b second out_valid", 32'(out_valid), 32'd1);

    // Flush overrides a simultaneous capture; data path still loads.
    @(negedge clk);
    flush   = 1'b1;
    rs_addr = 5'd6;
    rf_data = 32'h6666_6666;
    @(posedge clk);
    #1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush out_data", out_data, 32'h6666_6666);
    // Hazard during flush must not count as a stall.
    @(negedge clk);
    rs_addr  = 5'd8;
    fwd_wren = 3'b001;
    fwd_pend = 3'b001;
    fwd_addr = {5'd0, 5'd0, 5'd8};
    @(posedge clk);
    #1;
    chk("flush hazard stall_cnt", 32'(stall_cnt), 32'(exp_cnt(2)));
    chk("flush hazard out_valid", 32'(out_valid), 32'd0);

    // Saturation: 65540 hazard cycles on top of the existing count of 2.
    @(negedge clk);
    flush = 1'b0;
    repeat (65532) @(posedge clk);
    #1;
    chk("stall_cnt near saturation", 32'(stall_cnt), 32'(exp_cnt(65534)));
    repeat (8) @(posedge clk);
    #1;
    chk("stall_cnt saturated", 32'(stall_cnt), 32'(exp_cnt(65542)));
    chk("saturation out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
